// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS execute stage.
// Multiply completes after MUL_CYCLES edges; divide runs one restoring step per edge then sign-fixes.
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // multiplicand during MUL, dividend/quotient during DIV
  logic [WIDTH-1:0] dsr_q, dsr_d;   // multiplier during MUL, divisor magnitude during DIV
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d;

  function automatic logic [2*WIDTH-1:0] mul_ext(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sgn);
    logic [2*WIDTH-1:0] xe, ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_prod;

  assign a_neg    = ~op[0] & a[WIDTH-1];
  assign b_neg    = ~op[0] & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_sh   = {rem_q, quo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, dsr_q};
  assign mul_prod = mul_ext(quo_q, dsr_q, sgn_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        cnt_d = '0;
        if (!op[1])        state_d = (MUL_CYCLES == 1) ? S_IDLE : S_MUL;
        else if (b == '0)  state_d = S_FIX;
        else               state_d = S_DIV;
      end
      S_MUL: if (cnt_q == MUL_LAST) state_d = S_IDLE;
             else                   cnt_d   = cnt_q + CW'(1);
      S_DIV: if (cnt_q == DIV_LAST) state_d = S_FIX;
             else                   cnt_d   = cnt_q + CW'(1);
      S_FIX: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          sgn_d = ~op[0];
          if (!op[1]) begin
            quo_d = a;
            dsr_d = b;
            if (MUL_CYCLES == 1) begin
              {hi_d, lo_d} = mul_ext(a, b, ~op[0]);
              done_d       = 1'b1;
            end
          end else if (b == '0) begin
            // Divide by zero: skip iterations, FIX writes lo=all ones, hi=dividend.
            quo_d     = '1;
            rem_d     = a;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            quo_d     = a_mag;
            dsr_d     = b_mag;
            rem_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_MUL: if (cnt_q == MUL_LAST) begin
        {hi_d, lo_d} = mul_prod;
        done_d       = 1'b1;
      end
      S_DIV: begin
        if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      S_FIX: begin
        lo_d   = neg_quo_q ? -quo_q : quo_q;
        hi_d   = neg_rem_q ? -rem_q : rem_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops against
// an arithmetic reference model (latency countdown + plain signed/unsigned math).
module tb_mul_div_unit;
  localparam int W  = 32;
  localparam int MC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0, b = '0, wdata = '0;
  logic          mthi = 1'b0, mtlo = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;
  logic         m_done = 1'b0;

  mul_div_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] rh, output logic [W-1:0] rl, output int lat);
    logic [63:0] pr;
    int          sq, sr;
    if (!o[1]) begin
      if (o[0]) pr = {32'b0, x} * {32'b0, y};
      else      pr = 64'(longint'(int'(x)) * longint'(int'(y)));
      rh  = pr[63:32];
      rl  = pr[31:0];
      lat = MC;
    end else begin
      lat = (y == 0) ? 1 : W + 1;
      if (y == 0) begin
        rl = '1;
        rh = x;
      end else if (o[0]) begin
        rl = x / y;
        rh = x % y;
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        rl = 32'h8000_0000;
        rh = '0;
      end else begin
        sq = int'(x) / int'(y);
        sr = int'(x) % int'(y);
        rl = sq;
        rh = sr;
      end
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else begin
      if (mthi) m_hi = wdata;
      if (mtlo) m_lo = wdata;
      if (start) model_op(op, a, b, p_hi, p_lo, m_left);
    end
  endtask

  // One clock edge: advance the model from pre-edge inputs, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    if (!done) check("done_timeout", done, 1'b1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wait_done(lat);
  endtask

  // Continuous comparison of every output against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("busy", busy, m_left > 0);
      check("done", done, m_done);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int r;
    logic [W-1:0] x, y;

    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_hilo", {hi, lo}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // MULTU max*max
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("multu_lat", lat, MC);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("model_multu", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);
    tick();

    // MULT -3*7
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, lat);
    check("mult_lat", lat, MC);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("model_mult", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // DIV -7/2 and DIVU 100/7
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_lat", lat, W + 1);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_div", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b11, 32'd100, 32'd7, lat);
    check("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    // Divide by zero and signed overflow
    issue(2'b10, 32'h1234, 32'd0, lat);
    check("div0_lat", lat, 1);
    check("div0_hilo", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divovf_hilo", {hi, lo}, {32'h0, 32'h8000_0000});
    check("model_divovf", {m_hi, m_lo}, {32'h0, 32'h8000_0000});

    // Start and mthi while busy are ignored
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; a = 32'd1; b = 32'd1; mthi = 1'b1; wdata = 32'hAA;
    tick();
    start = 1'b0; mthi = 1'b0;
    wait_done(lat);
    check("busy_ign_hilo", {hi, lo}, {32'd2, 32'd14});
    tick();
    mthi = 1'b1; wdata = 32'hAA;
    tick();
    mthi = 1'b0;
    check("mthi_idle", {hi, lo}, {32'hAA, 32'd14});

    // Start held high: ignored on the edge busy falls, accepted one cycle later
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    tick();
    repeat (MC) tick();
    check("held_done", {busy, done}, 2'b01);
    check("held_lo", lo, 32'd15);
    a = 32'd6; b = 32'd9;
    tick();
    start = 1'b0;
    check("held_relaunch", busy, 1'b1);
    wait_done(lat);
    check("held_lo2", lo, 32'd54);

    // Reset in the middle of a DIV
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    issue(2'b01, 32'd6, 32'd7, lat);
    check("post_rst_mul", {hi, lo}, {32'd0, 32'd42});

    // Random ops with occasional mt* writes alongside start and in idle gaps
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      x = $urandom;
      y = $urandom;
      if (r == 0) y = '0;
      else if (r == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (r == 2) y = $urandom_range(1, 16);
      else if (r == 3) y = -$urandom_range(1, 16);
      mthi  = ($urandom_range(0, 3) == 0);
      mtlo  = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      issue(2'($urandom_range(0, 3)), x, y, lat);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        mthi  = ($urandom_range(0, 1) == 0);
        mtlo  = ($urandom_range(0, 1) == 0);
        wdata = $urandom;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
      end
    end

    tick(); tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
